// File: rtl/seq_unsi_div_24b_pkg.sv
// Shared definitions for the sequential unsigned divider.
// Holds the default operand width and the controller states.
package seq_unsi_div_24b_pkg;

  localparam int DW_DEF = 12;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

endpackage

// File: rtl/unsi_div_step.sv
// One restoring-division step: compare the shifted partial
// remainder against the divisor and subtract when it fits.
module unsi_div_step #(
  parameter int DW = 12
) (
  input  logic [DW:0]   tmp,
  input  logic [DW-1:0] dvs,
  output logic [DW-1:0] prem,
  output logic          qbit
);

  // When tmp >= dvs the difference is below dvs < 2**DW,
  // so the low DW bits of the subtraction are exact.
  always_comb begin
    qbit = (tmp >= {1'b0, dvs});
    prem = qbit ? (tmp[DW-1:0] - dvs) : tmp[DW-1:0];
  end

endmodule

// File: rtl/seq_unsi_div_24b.sv
// Sequential restoring divider: 2*DW-bit dividend by DW-bit
// divisor, one quotient bit per cycle, flags for /0 and overflow.
module seq_unsi_div_24b
  import seq_unsi_div_24b_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_vld,
  output logic            in_rdy,
  input  logic [2*DW-1:0] dvd,
  input  logic [DW-1:0]   dvs,
  output logic            out_vld,
  input  logic            out_rdy,
  output logic [DW-1:0]   quo,
  output logic [DW-1:0]   rem,
  output logic            dz,
  output logic            ovf
);

  localparam int CW = $clog2(DW + 1);

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] cnt;
  logic [DW-1:0] prem;
  logic [DW-1:0] qsr;
  logic [DW-1:0] dvs_r;
  logic [DW-1:0] prem_nx;
  logic          qbit;
  logic          acc;
  logic          dz_in;
  logic          ovf_in;
  logic          last;

  assign in_rdy  = (state == IDLE);
  assign out_vld = (state == DONE);
  assign acc     = in_vld && in_rdy;
  assign dz_in   = (dvs == '0);
  assign ovf_in  = !dz_in && (dvd[2*DW-1:DW] >= dvs);
  assign last    = (cnt == CW'(DW - 1));

  unsi_div_step #(
    .DW(DW)
  ) u_step (
    .tmp  ({prem, qsr[DW-1]}),
    .dvs  (dvs_r),
    .prem (prem_nx),
    .qbit (qbit)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (acc) state_nx = (dz_in || ovf_in) ? DONE : CALC;
      end
      CALC: begin
        if (last) state_nx = DONE;
      end
      DONE: begin
        if (out_rdy) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      prem  <= '0;
      qsr   <= '0;
      dvs_r <= '0;
      quo   <= '0;
      rem   <= '0;
      dz    <= 1'b0;
      ovf   <= 1'b0;
    end else if (acc) begin
      dvs_r <= dvs;
      cnt   <= '0;
      prem  <= dvd[2*DW-1:DW];
      qsr   <= dvd[DW-1:0];
      // Flagged results are known immediately; skip iteration.
      if (dz_in || ovf_in) begin
        quo <= '1;
        rem <= dvd[DW-1:0];
        dz  <= dz_in;
        ovf <= ovf_in;
      end
    end else if (state == CALC) begin
      prem <= prem_nx;
      qsr  <= {qsr[DW-2:0], qbit};
      cnt  <= cnt + CW'(1);
      if (last) begin
        quo <= {qsr[DW-2:0], qbit};
        rem <= prem_nx;
        dz  <= 1'b0;
        ovf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seq_unsi_div_24b.sv
// Self-checking bench for seq_unsi_div_24b: directed vectors,
// randomized operands against an arithmetic model, backpressure, reset.
module tb_seq_unsi_div_24b;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_vld;
  logic        in_rdy;
  logic [23:0] dvd;
  logic [11:0] dvs;
  logic        out_vld;
  logic        out_rdy;
  logic [11:0] quo;
  logic [11:0] rem;
  logic        dz;
  logic        ovf;

  int checks   = 0;
  int failures = 0;

  seq_unsi_div_24b #(.DW(12)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (in_vld),
    .in_rdy  (in_rdy),
    .dvd     (dvd),
    .dvs     (dvs),
    .out_vld (out_vld),
    .out_rdy (out_rdy),
    .quo     (quo),
    .rem     (rem),
    .dz      (dz),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  task automatic model(input logic [23:0] a, input logic [11:0] b,
                       output logic [11:0] q, output logic [11:0] r,
                       output logic z, output logic o, output int lat);
    int unsigned ai;
    int unsigned bi;
    ai = a;
    bi = b;
    if (bi == 0) begin
      q = 12'hFFF; r = a[11:0]; z = 1'b1; o = 1'b0; lat = 1;
    end else if ((ai >> 12) >= bi) begin
      q = 12'hFFF; r = a[11:0]; z = 1'b0; o = 1'b1; lat = 1;
    end else begin
      q = 12'(ai / bi); r = 12'(ai % bi); z = 1'b0; o = 1'b0; lat = 13;
    end
  endtask

  // Present one operand pair, then wait for out_vld (out_rdy held low).
  task automatic run_op(input logic [23:0] a, input logic [11:0] b,
                        output int lat, output bit to);
    int n;
    to  = 1'b0;
    lat = 0;
    n   = 0;
    while (!in_rdy && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_rdy) begin
      to = 1'b1;
      return;
    end
    dvd = a;
    dvs = b;
    in_vld = 1'b1;
    @(posedge clk); #1;
    in_vld = 1'b0;
    dvd = 24'($urandom);
    dvs = 12'($urandom);
    lat = 1;
    while (!out_vld && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_vld) to = 1'b1;
  endtask

  task automatic release_result();
    out_rdy = 1'b1;
    @(posedge clk); #1;
    out_rdy = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({out_vld, quo, rem, dz, ovf} !== 27'd0) begin
      failures++;
      $display("FAIL reset_outputs: got vld=%b quo=%h rem=%h dz=%b ovf=%b, want all 0",
               out_vld, quo, rem, dz, ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_rdy !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_rdy: got %b want 1", in_rdy);
    end
  endtask

  task automatic test_directed();
    logic [23:0] ta [4];
    logic [11:0] tb [4];
    logic [11:0] eq [4];
    logic [11:0] er [4];
    logic [1:0]  ef [4];
    int          el [4];
    int          lat;
    bit          to;
    ta = '{24'h000C35, 24'h0FFFFF, 24'h123456, 24'h00A000};
    tb = '{12'h019, 12'hFFF, 12'h000, 12'h00A};
    eq = '{12'h07D, 12'h100, 12'hFFF, 12'hFFF};
    er = '{12'h000, 12'h0FF, 12'h456, 12'h000};
    ef = '{2'b00, 2'b00, 2'b10, 2'b01};
    el = '{13, 13, 1, 1};
    for (int i = 0; i < 4; i++) begin
      run_op(ta[i], tb[i], lat, to);
      checks++;
      if (to) begin
        failures++;
        $display("FAIL dir%0d_timeout: no out_vld after %0d cycles", i, lat);
        continue;
      end
      checks++;
      if ({quo, rem, dz, ovf} !== {eq[i], er[i], ef[i]}) begin
        failures++;
        $display("FAIL dir%0d_result: got quo=%h rem=%h dz=%b ovf=%b want quo=%h rem=%h dz/ovf=%b",
                 i, quo, rem, dz, ovf, eq[i], er[i], ef[i]);
      end
      checks++;
      if (lat != el[i]) begin
        failures++;
        $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, el[i]);
      end
      release_result();
    end
  endtask

  task automatic test_random();
    logic [23:0] a;
    logic [11:0] b;
    logic [11:0] hi;
    logic [11:0] q;
    logic [11:0] r;
    logic        z;
    logic        o;
    int          el;
    int          lat;
    bit          to;
    int unsigned mode;
    for (int i = 0; i < 60; i++) begin
      mode = $urandom_range(0, 9);
      b = 12'($urandom_range(1, 4095));
      if (mode == 0) b = 12'h000;
      if (mode == 1) hi = 12'($urandom_range(int'(b), 4095));
      else if (b == 0) hi = 12'($urandom);
      else hi = 12'($urandom_range(0, int'(b) - 1));
      a = {hi, 12'($urandom)};
      model(a, b, q, r, z, o, el);
      run_op(a, b, lat, to);
      checks++;
      if (to) begin
        failures++;
        $display("FAIL rnd%0d_timeout: no out_vld", i);
        continue;
      end
      checks++;
      if ({quo, rem, dz, ovf} !== {q, r, z, o} || lat != el) begin
        failures++;
        $display("FAIL rnd%0d: dvd=%h dvs=%h got quo=%h rem=%h dz=%b ovf=%b lat=%0d want %h %h %b %b %0d",
                 i, a, b, quo, rem, dz, ovf, lat, q, r, z, o, el);
      end
      if (!z && !o) begin
        checks++;
        if (32'(quo) * 32'(b) + 32'(rem) != 32'(a) || rem >= b) begin
          failures++;
          $display("FAIL rnd%0d_identity: quo*dvs+rem=%0d want %0d (rem=%h dvs=%h)",
                   i, 32'(quo) * 32'(b) + 32'(rem), a, rem, b);
        end
      end
      release_result();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    bit to;
    run_op(24'h000C35, 12'h019, lat, to);
    checks++;
    if (to) begin
      failures++;
      $display("FAIL bp_timeout: no out_vld");
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({out_vld, in_rdy, quo, rem, dz, ovf} !== {2'b10, 12'h07D, 12'h000, 2'b00}) begin
        failures++;
        $display("FAIL bp_hold%0d: vld=%b rdy=%b quo=%h rem=%h dz=%b ovf=%b want 1 0 07d 000 0 0",
                 i, out_vld, in_rdy, quo, rem, dz, ovf);
      end
    end
    release_result();
    checks++;
    if (out_vld !== 1'b0 || in_rdy !== 1'b1) begin
      failures++;
      $display("FAIL bp_idle: vld=%b rdy=%b want 0 1", out_vld, in_rdy);
    end
    dvd = 24'h0FFFFF;
    dvs = 12'hFFF;
    in_vld = 1'b1;
    @(posedge clk); #1;
    in_vld = 1'b0;
    checks++;
    if (in_rdy !== 1'b0) begin
      failures++;
      $display("FAIL bp_b2b_accept: in_rdy=%b want 0", in_rdy);
    end
    lat = 1;
    while (!out_vld && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (!out_vld || lat != 13 || {quo, rem} !== {12'h100, 12'h0FF}) begin
      failures++;
      $display("FAIL bp_b2b_result: vld=%b lat=%0d quo=%h rem=%h want 1 13 100 0ff",
               out_vld, lat, quo, rem);
    end
    release_result();
  endtask

  task automatic test_reset_midcalc();
    int lat;
    bit to;
    int n;
    n = 0;
    while (!in_rdy && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (quo === 12'h000) begin
      failures++;
      $display("FAIL rstcalc_pre: quo=%h want nonzero leftover", quo);
    end
    dvd = 24'h000C35;
    dvs = 12'h019;
    in_vld = 1'b1;
    @(posedge clk); #1;
    in_vld = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_vld, in_rdy, quo, rem} !== {2'b01, 24'h0}) begin
      failures++;
      $display("FAIL rstcalc_abort: vld=%b rdy=%b quo=%h rem=%h want 0 1 000 000",
               out_vld, in_rdy, quo, rem);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(24'h000C35, 12'h019, lat, to);
    checks++;
    if (to || lat != 13 || {quo, rem, dz, ovf} !== {12'h07D, 12'h000, 2'b00}) begin
      failures++;
      $display("FAIL rstcalc_fresh: to=%b lat=%0d quo=%h rem=%h dz=%b ovf=%b want 0 13 07d 000 0 0",
               to, lat, quo, rem, dz, ovf);
    end
    release_result();
  endtask

  initial begin
    in_vld  = 1'b0;
    out_rdy = 1'b0;
    dvd     = '0;
    dvs     = '0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_midcalc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_unsi_div_24b.md
SEQ_UNSI_DIV_24B -- requirements
Module: seq_unsi_div_24b

Interface
REQ-001 SHALL have parameter DW, default 12, meaning divisor, quotient and remainder width; the dividend is 2*DW bits wide.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port in_vld, input, 1 bit: the operand pair is valid.
REQ-005 SHALL have port in_rdy, output, 1 bit: the block can accept operands.
REQ-006 SHALL have port dvd, input, 2*DW bits: unsigned dividend.
REQ-007 SHALL have port dvs, input, DW bits: unsigned divisor.
REQ-008 SHALL have port out_vld, output, 1 bit: the result is valid.
REQ-009 SHALL have port out_rdy, input, 1 bit: the consumer accepts the result.
REQ-010 SHALL have port quo, output, DW bits: quotient.
REQ-011 SHALL have port rem, output, DW bits: remainder.
REQ-012 SHALL have port dz, output, 1 bit: divide-by-zero flag.
REQ-013 SHALL have port ovf, output, 1 bit: quotient-overflow flag.

Function
REQ-014 SHALL implement FSM states IDLE, CALC and DONE.
REQ-015 SHALL drive in_rdy=1 only in IDLE, decoded from state only, with no combinational path from in_vld or out_rdy.
REQ-016 SHALL treat acceptance as in_vld&&in_rdy, latch dvd and dvs on that edge, and ignore operand changes afterwards.
REQ-017 On acceptance with dvs==0, SHALL go to DONE with dz=1, ovf=0, quo={DW{1'b1}}, rem=dvd[DW-1:0].
REQ-018 On acceptance with dvs!=0 and dvd[2DW-1:DW]>=dvs, SHALL go to DONE with ovf=1, dz=0, quo={DW{1'b1}}, rem=dvd[DW-1:0].
REQ-019 Otherwise SHALL go to CALC with partial remainder=dvd[2DW-1:DW], quotient shift register=dvd[DW-1:0], and iteration counter=0.
REQ-020 In CALC, each cycle SHALL perform one restoring step:
  - form tmp={prem,qsr[DW-1]} (DW+1 bits);
  - if tmp>=dvs: prem=tmp-dvs and shift 1 into qsr LSB;
  - else: prem=tmp[DW-1:0] and shift 0 into qsr LSB.
REQ-021 SHALL perform exactly DW CALC cycles, then enter DONE with quo=qsr, rem=prem, dz=0, ovf=0.
REQ-022 SHALL assert out_vld in DONE only; latency from the acceptance edge to out_vld is DW+1 cycles for a normal division and 1 cycle for dz/ovf.
REQ-023 SHALL hold quo, rem, dz and ovf stable while out_vld=1 and out_rdy=0.
REQ-024 On out_vld&&out_rdy, SHALL go to IDLE; a new operand pair is acceptable the following cycle (throughput is one division per DW+2 cycles).
REQ-025 quo, rem, dz and ovf SHALL retain their last values in IDLE and CALC; out_vld=0 marks them invalid.
REQ-026 For every non-flagged result, dvd == quo*dvs + rem with rem<dvs SHALL hold.

Reset
REQ-027 On rst_n low, SHALL asynchronously force state=IDLE, counter=0, out_vld=0, quo=0, rem=0, dz=0 and ovf=0.
REQ-028 A reset asserted during CALC or DONE SHALL abort the operation and discard the result.
REQ-029 After reset release, in_rdy SHALL be 1 in the first cycle.

Structure
REQ-030 The shared package SHALL hold the default DW (12) and the FSM state enum.
REQ-031 One combinational sub-module unsi_div_step SHALL implement the compare-subtract of REQ-020 (inputs tmp and dvs; outputs new prem and quotient bit).
REQ-032 The counter SHALL be $clog2(DW+1) bits wide.

Verification
REQ-033 dvd=24'h000C35, dvs=12'h019 -> out_vld 13 cycles after acceptance; quo=12'h07D, rem=12'h000, dz=0, ovf=0.
REQ-034 dvd=24'h0FFFFF, dvs=12'hFFF -> quo=12'h100, rem=12'h0FF.
REQ-035 dvs=12'h000, dvd=24'h123456 -> out_vld 1 cycle after acceptance; dz=1, quo=12'hFFF, rem=12'h456.
REQ-036 dvd=24'h00A000, dvs=12'h00A -> ovf=1, dz=0, quo=12'hFFF, rem=12'h000, latency 1.
REQ-037 Backpressure case:
  - hold out_rdy=0 for 5 cycles in DONE -> outputs stable and in_rdy=0 throughout;
  - out_rdy=1 -> IDLE the next cycle;
  - a back-to-back second operand pair -> accepted that cycle.
REQ-038 Pulse rst_n low at CALC iteration 6 -> out_vld=0 and quo=rem=0 immediately; after release, a fresh 24'h000C35/12'h019 division still returns 12'h07D/12'h000.
